// File: rtl/alu_pkg.sv
// Shared op codes, branch-compare codes, FSM state encoding and small helpers for alu_mc_seq.
// The BUSY state only exists when ALU_MULDIV_EN is defined.
package alu_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SLL   = 4'b0100;
  localparam logic [3:0] ALU_SRL   = 4'b0101;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SRA   = 4'b0111;
  localparam logic [3:0] ALU_SLT   = 4'b1000;
  localparam logic [3:0] ALU_SLTU  = 4'b1001;
  localparam logic [3:0] ALU_XOR   = 4'b1010;
  localparam logic [3:0] ALU_MUL   = 4'b1011;
  localparam logic [3:0] ALU_NOR   = 4'b1100;
  localparam logic [3:0] ALU_MULHU = 4'b1101;
  localparam logic [3:0] ALU_DIVU  = 4'b1110;
  localparam logic [3:0] ALU_REMU  = 4'b1111;

  localparam logic [2:0] BR_EQZ = 3'b000;
  localparam logic [2:0] BR_NEZ = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
`ifdef ALU_MULDIV_EN
    BUSY = 2'd3,
`endif
    DONE = 2'd2
  } state_t;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_MULHU) || (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

  function automatic logic branch_flag(input logic [2:0] f3, input logic res_zero,
                                       input logic lt_s, input logic lt_u);
    logic flag;
    flag = 1'b0;
    case (f3)
      BR_EQZ:  flag = res_zero;
      BR_NEZ:  flag = !res_zero;
      BR_LT:   flag = lt_s;
      BR_GE:   flag = !lt_s;
      BR_LTU:  flag = lt_u;
      BR_GEU:  flag = !lt_u;
      default: flag = 1'b0;
    endcase
    return flag;
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unit: right-shifting shift-add multiplier and restoring divider sharing one register pair.
// Runs exactly XLEN iterations after start; done stays high until the cycle after it is seen.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] res
);
  localparam int CW = $clog2(XLEN) + 1;

  logic [CW-1:0]   cnt_q, cnt_d;
  logic            run_q, run_d;
  logic [3:0]      op_q, op_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d;
  logic [XLEN:0]   sum, shifted, trial;
  logic            is_div, start_div;

  always_comb begin
    is_div    = (op_q == ALU_DIVU) || (op_q == ALU_REMU);
    start_div = (op == ALU_DIVU) || (op == ALU_REMU);
    sum       = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    shifted   = {hi_q, lo_q[XLEN-1]};
    trial     = shifted - {1'b0, m_q};
    done      = run_q && (cnt_q == '0);
    cnt_d     = cnt_q;
    run_d     = run_q;
    op_d      = op_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    m_d       = m_q;
    // hi holds the upper product / partial remainder, lo the multiplier / dividend-then-quotient
    if (start) begin
      run_d = 1'b1;
      cnt_d = CW'(XLEN);
      op_d  = op;
      hi_d  = '0;
      lo_d  = start_div ? a : b;
      m_d   = start_div ? b : a;
    end else if (done) begin
      run_d = 1'b0;
    end else if (run_q) begin
      cnt_d = cnt_q - CW'(1);
      if (is_div) begin
        if (!trial[XLEN]) begin
          hi_d = trial[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], 1'b1};
        end else begin
          hi_d = shifted[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], 1'b0};
        end
      end else begin
        hi_d = sum[XLEN:1];
        lo_d = {sum[0], lo_q[XLEN-1:1]};
      end
    end
    case (op_q)
      ALU_MUL:  res = lo_q;
      ALU_DIVU: res = lo_q;
      default:  res = hi_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
      run_q <= 1'b0;
      op_q  <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      m_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
      op_q  <= op_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      m_q   <= m_d;
    end
  end

endmodule

// File: rtl/alu_mc_seq.sv
// Multi-cycle ALU with valid/ready on both sides; MUL/MULHU/DIVU/REMU use the iterative unit
// only when ALU_MULDIV_EN is defined, otherwise they complete in one cycle as illegal ops.
module alu_mc_seq
  import alu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      operation,
  input  logic [2:0]      func3,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal,
  output state_t          dbg_state
);
  localparam int SHW = $clog2(XLEN);

  state_t          state_q, state_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [3:0]      op_q, op_d;
  logic [2:0]      f3_q, f3_d;
  logic            zero_q, zero_d, illegal_q, illegal_d;
  logic [XLEN-1:0] alu_res, fin_res;
  logic            alu_ill, fin_ill, fin, lt_s, lt_u;
  logic [SHW-1:0]  shamt;

  // Handshake: a request transfers on a clock edge where in_valid && in_ready, a result on one
  // where out_valid && out_ready; in_ready is high only in IDLE, out_valid only in DONE.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;
  assign dbg_state = state_q;

`ifdef ALU_MULDIV_EN
  logic            md_start, md_done;
  logic [XLEN-1:0] md_res;

  assign md_start = (state_q == IDLE) && in_valid && is_muldiv(operation);

  alu_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk   (clk),
    .reset (reset),
    .start (md_start),
    .op    (operation),
    .a     (a),
    .b     (b),
    .done  (md_done),
    .res   (md_res)
  );
`endif

  always_comb begin
    shamt   = b_q[SHW-1:0];
    lt_s    = $signed(a_q) < $signed(b_q);
    lt_u    = a_q < b_q;
    alu_res = '0;
    alu_ill = 1'b0;
    case (op_q)
      ALU_AND:  alu_res = a_q & b_q;
      ALU_OR:   alu_res = a_q | b_q;
      ALU_ADD:  alu_res = a_q + b_q;
      ALU_SUB:  alu_res = a_q - b_q;
      ALU_NOR:  alu_res = ~(a_q | b_q);
      ALU_SLL:  alu_res = a_q << shamt;
      ALU_SRL:  alu_res = a_q >> shamt;
      ALU_SRA:  alu_res = $signed(a_q) >>> shamt;
      ALU_SLT:  alu_res = XLEN'(lt_s);
      ALU_SLTU: alu_res = XLEN'(lt_u);
      ALU_XOR:  alu_res = a_q ^ b_q;
      default:  alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    f3_d      = f3_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    fin       = 1'b0;
    fin_res   = alu_res;
    fin_ill   = alu_ill;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          op_d    = operation;
          f3_d    = func3;
          state_d = EXEC;
`ifdef ALU_MULDIV_EN
          if (is_muldiv(operation)) state_d = BUSY;
`endif
        end
      end
      EXEC: begin
        fin     = 1'b1;
        state_d = DONE;
      end
`ifdef ALU_MULDIV_EN
      BUSY: begin
        if (md_done) begin
          fin     = 1'b1;
          fin_res = md_res;
          fin_ill = 1'b0;
          state_d = DONE;
        end
      end
`endif
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Result, flag and illegal only change when an op completes, so they hold under backpressure
    if (fin) begin
      result_d  = fin_res;
      illegal_d = fin_ill;
      zero_d    = branch_flag(f3_q, fin_res == '0, lt_s, lt_u);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      f3_q      <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      f3_q      <= f3_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_alu_mc_seq.sv
// Randomized and directed bench for alu_mc_seq (XLEN=64) against an arithmetic reference model;
// follows ALU_MULDIV_EN the same way as the design build.
module tb_alu_mc_seq;
  import alu_pkg::*;

  localparam int XLEN = 64;

  logic            clk;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [3:0]      operation;
  logic [2:0]      func3;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;
  state_t          dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [XLEN+1:0] exp_q[$];

  alu_mc_seq #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .operation (operation),
    .func3     (func3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal),
    .dbg_state (dbg_state)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: plain arithmetic on full-width integers
  function automatic void ref_model(input logic [3:0] op, input logic [63:0] x, input logic [63:0] y,
                                    input logic [2:0] f3, output logic [63:0] r, output logic z,
                                    output logic il, output int lat);
    logic [127:0] p;
    int sh;
    sh  = int'(y % 64);
    p   = {64'd0, x} * {64'd0, y};
    r   = 64'd0;
    il  = 1'b0;
    lat = 2;
    case (op)
      4'b0000: r = x & y;
      4'b0001: r = x | y;
      4'b0010: r = x + y;
      4'b0110: r = x - y;
      4'b1100: r = ~(x | y);
      4'b0100: r = x << sh;
      4'b0101: r = x >> sh;
      4'b0111: r = $signed(x) >>> sh;
      4'b1000: r = ($signed(x) < $signed(y)) ? 64'd1 : 64'd0;
      4'b1001: r = (x < y) ? 64'd1 : 64'd0;
      4'b1010: r = x ^ y;
      4'b1011, 4'b1101, 4'b1110, 4'b1111: begin
`ifdef ALU_MULDIV_EN
        lat = XLEN + 2;
        if (op == 4'b1011)      r = p[63:0];
        else if (op == 4'b1101) r = p[127:64];
        else if (op == 4'b1110) r = (y == 0) ? {64{1'b1}} : x / y;
        else                    r = (y == 0) ? x : x % y;
`else
        r  = 64'd0;
        il = 1'b1;
`endif
      end
      default: begin
        r  = 64'd0;
        il = 1'b1;
      end
    endcase
    case (f3)
      3'b000:  z = (r == 0);
      3'b001:  z = (r != 0);
      3'b100:  z = $signed(x) < $signed(y);
      3'b101:  z = $signed(x) >= $signed(y);
      3'b110:  z = x < y;
      3'b111:  z = x >= y;
      default: z = 1'b0;
    endcase
  endfunction

  // driver: call and return on a negedge
  task automatic run_op(input string tag, input logic [3:0] op, input logic [63:0] av,
                        input logic [63:0] bv, input logic [2:0] f3, input int hold);
    logic [63:0]     er, held;
    logic            ez, ei, rdy_bad, hold_bad, got;
    logic [XLEN+1:0] e;
    int              elat, lat;
    ref_model(op, av, bv, f3, er, ez, ei, elat);
    exp_q.push_back({ei, ez, er});
    check({tag, ":in_ready"}, 64'(in_ready), 64'd1);
    in_valid  = 1'b1;
    a         = av;
    b         = bv;
    operation = op;
    func3     = f3;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    a         = {$urandom, $urandom};
    b         = {$urandom, $urandom};
    operation = 4'($urandom);
    func3     = 3'($urandom);
    lat = 1;
    got = 1'b0;
    rdy_bad = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1'b1;
        break;
      end
      if (in_ready) rdy_bad = 1'b1;
      lat++;
    end
    check({tag, ":out_valid_seen"}, 64'(got), 64'd1);
    check({tag, ":latency"}, 64'(lat), 64'(elat));
    check({tag, ":ready_low"}, 64'(rdy_bad), 64'd0);
    e = exp_q.pop_front();
    check({tag, ":result"}, result, e[63:0]);
    check({tag, ":zero"}, 64'(zero), 64'(e[64]));
    check({tag, ":illegal"}, 64'(illegal), 64'(e[65]));
    held = result;
    hold_bad = 1'b0;
    repeat (hold) begin
      @(negedge clk);
      if (!out_valid || result !== held || zero !== e[64] || illegal !== e[65]) hold_bad = 1'b1;
    end
    if (hold > 0) check({tag, ":held"}, 64'(hold_bad), 64'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check({tag, ":released"}, 64'(out_valid), 64'd0);
  endtask

  function automatic logic [63:0] pick_operand();
    case ($urandom_range(0, 3))
      0:       return {$urandom, $urandom};
      1:       return 64'($urandom_range(0, 20));
      2:       return ($urandom_range(0, 1) == 1) ? {64{1'b1}} : 64'h8000_0000_0000_0000;
      default: return {32'd0, $urandom};
    endcase
  endfunction

  initial begin
    logic saw;
    reset     = 1'b0;
    in_valid  = 1'b1;
    a         = 64'h1234;
    b         = 64'h5678;
    operation = 4'b0010;
    func3     = 3'b000;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst:out_valid_in_reset", 64'(out_valid), 64'd0);
    reset    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst:out_valid", 64'(out_valid), 64'd0);
    check("rst:in_ready", 64'(in_ready), 64'd1);
    check("rst:result", result, 64'd0);
    check("rst:zero", 64'(zero), 64'd0);
    check("rst:illegal", 64'(illegal), 64'd0);
    check("rst:state", 64'(dbg_state), 64'(IDLE));

    run_op("add_wrap", 4'b0010, {64{1'b1}}, 64'd1, 3'b000, 0);
    run_op("cmp_lt", 4'b0110, {64{1'b1}}, 64'd1, 3'b100, 0);
    run_op("cmp_ltu", 4'b0110, {64{1'b1}}, 64'd1, 3'b110, 0);
    run_op("sra", 4'b0111, {64{1'b1}}, 64'd4, 3'b001, 0);
    run_op("sll_wide_b", 4'b0100, 64'h1, 64'hFFFF_0000_0000_0043, 3'b000, 0);
    run_op("illegal_0011", 4'b0011, 64'h55, 64'h66, 3'b000, 0);
    run_op("mul", 4'b1011, 64'h1_0000_0000, 64'h1_0000_0000, 3'b000, 0);
    run_op("mulhu", 4'b1101, 64'h1_0000_0000, 64'h1_0000_0000, 3'b001, 0);
    run_op("divu", 4'b1110, 64'd100, 64'd7, 3'b000, 0);
    run_op("remu", 4'b1111, 64'd100, 64'd7, 3'b111, 0);
    run_op("divu_by0", 4'b1110, 64'd100, 64'd0, 3'b000, 0);
    run_op("remu_by0", 4'b1111, 64'd100, 64'd0, 3'b000, 0);
    run_op("backpressure", 4'b1010, 64'hF0F0, 64'h0FF0, 3'b101, 5);

    for (int i = 0; i < 40; i++) begin
      run_op("rand", 4'($urandom_range(0, 15)), pick_operand(), pick_operand(),
             3'($urandom_range(0, 7)), $urandom_range(0, 2));
    end

    // abort: reset while a long op is in flight delivers nothing
    in_valid  = 1'b1;
    a         = 64'd100;
    b         = 64'd7;
    operation = 4'b1110;
    func3     = 3'b000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("abort:out_valid", 64'(out_valid), 64'd0);
    check("abort:in_ready", 64'(in_ready), 64'd1);
    check("abort:result", result, 64'd0);
    saw = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (out_valid) saw = 1'b1;
    end
    check("abort:no_result", 64'(saw), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
